// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit SRAM driver between a CPU port (0) and a
// secondary master (1). Round-robin arbitration with an owner lock so that
// multi-word accesses stay atomic, capped at MAX_BURST consecutive grants.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_valid,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_valid,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  sram_valid,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic                  sram_ready,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  busy,
    output logic                  owner
);

    // Counter only needs to reach MAX_BURST-1 (the last locked re-grant).
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      burst_cnt;
    logic                  lock_q;
    logic                  done;
    logic                  owner_valid;
    logic                  owner_lock;
    logic                  win_valid;
    logic                  win_port;
    logic                  win_locked;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    // Completion is the driver's ready while a request is outstanding.
    assign done        = (state == GRANT) && sram_ready;
    assign owner_valid = owner ? m1_valid : m0_valid;
    assign owner_lock  = owner ? m1_lock  : m0_lock;

    // Ready is steered to the owner in the same cycle; read data is shared.
    assign m0_ready = done && !owner;
    assign m1_ready = done &&  owner;
    assign m0_rdata = sram_rdata;
    assign m1_rdata = sram_rdata;

    // Winner selection: locked owner re-grant (GAP only, below the burst cap)
    // beats round-robin; a tie goes to the port that is not the last owner.
    always_comb begin
        win_valid  = 1'b0;
        win_port   = owner;
        win_locked = 1'b0;
        if ((state == GAP) && lock_q && owner_valid && (burst_cnt < BURST_LIMIT)) begin
            win_valid  = 1'b1;
            win_port   = owner;
            win_locked = 1'b1;
        end else if (m0_valid && m1_valid) begin
            win_valid = 1'b1;
            win_port  = ~owner;
        end else if (m0_valid) begin
            win_valid = 1'b1;
            win_port  = 1'b0;
        end else if (m1_valid) begin
            win_valid = 1'b1;
            win_port  = 1'b1;
        end
    end

    assign win_we    = win_port ? m1_we    : m0_we;
    assign win_addr  = win_port ? m1_addr  : m0_addr;
    assign win_wdata = win_port ? m1_wdata : m0_wdata;

    // Control FSM: captures the winner and holds the driver request until ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sram_valid <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            busy       <= 1'b0;
            owner      <= 1'b1;
            burst_cnt  <= '0;
            lock_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (win_valid) begin
                        sram_valid <= 1'b1;
                        sram_we    <= win_we;
                        sram_addr  <= win_addr;
                        sram_wdata <= win_wdata;
                        owner      <= win_port;
                        busy       <= 1'b1;
                        burst_cnt  <= win_locked ? (burst_cnt + CNT_W'(1)) : '0;
                        state      <= GRANT;
                    end else begin
                        sram_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                GRANT: begin
                    if (sram_ready) begin
                        sram_valid <= 1'b0;
                        lock_q     <= owner_lock;
                        state      <= GAP;
                    end
                end
                default: begin
                    sram_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with queue-driven masters,
// a fixed-latency SRAM driver model and an in-order completion scoreboard.
module tb_sram_arbiter;

    localparam int AW  = 19;
    localparam int DW  = 16;
    localparam int LAT = 3;

    typedef struct packed {
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_valid = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ready;
    logic [DW-1:0] m0_rdata;
    logic          m1_valid = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ready;
    logic [DW-1:0] m1_rdata;
    logic          sram_valid, sram_we, sram_ready;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic          busy, owner;

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];
    int   rise_q[$];
    int   done_q[$];
    int   fall_q[$];

    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   rdy0_n = 0;
    int   rdy1_n = 0;
    int   lat_cnt;
    logic sv_prev = 1'b0;
    logic drop1 = 1'b0;
    logic p0, p1;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .sram_valid(sram_valid), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
        .busy(busy), .owner(owner)
    );

    function automatic logic [DW-1:0] rd_f(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    // SRAM driver model: ready in the LAT+1-th cycle of a request, data from address
    always @(posedge clk or posedge reset) begin
        if (reset) lat_cnt <= 0;
        else if (sram_valid && !sram_ready) lat_cnt <= lat_cnt + 1;
        else lat_cnt <= 0;
    end
    assign sram_ready = sram_valid && (lat_cnt == LAT);
    assign sram_rdata = rd_f(sram_addr);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Completion monitor: scoreboard compare on every ready pulse
    always @(negedge clk) begin
        exp_t e;
        if (sram_valid && !sv_prev) rise_q.push_back(cyc);
        if (!sram_valid && sv_prev) fall_q.push_back(cyc);
        sv_prev = sram_valid;
        if (m0_ready || m1_ready) begin
            done_q.push_back(cyc);
            if (m0_ready) rdy0_n++;
            if (m1_ready) rdy1_n++;
            check("ready_onehot", 32'(m0_ready & m1_ready), 32'd0);
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("port", 32'(m1_ready), 32'(e.port));
                check("owner", 32'(owner), 32'(e.port));
                check("addr", 32'(sram_addr), 32'(e.addr));
                check("we", 32'(sram_we), 32'(e.we));
                if (e.we) check("wdata", 32'(sram_wdata), 32'(e.wdata));
                else check("rdata", 32'(e.port ? m1_rdata : m0_rdata), 32'(rd_f(e.addr)));
            end
        end
    end

    // Master models: present queue head, pop after the ready pulse
    always begin
        @(negedge clk);
        p0 = m0_ready;
        p1 = m1_ready;
        @(posedge clk);
        #1;
        if (p0 && q0.size() > 0) q0.delete(0);
        if (p1 && q1.size() > 0) q1.delete(0);
        if (q0.size() > 0) begin
            m0_valid = 1'b1; m0_we = q0[0].we; m0_lock = q0[0].lock;
            m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
        end else begin
            m0_valid = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
        end
        if (q1.size() > 0 && !drop1) begin
            m1_valid = 1'b1; m1_we = q1[0].we; m1_lock = q1[0].lock;
            m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
        end else if (q1.size() > 0) begin
            m1_valid = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '1; m1_wdata = 16'hDEAD;
        end else begin
            m1_valid = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
        end
    end

    task automatic req(input logic port, input logic we, input logic lock,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        r.we = we; r.lock = lock; r.addr = a; r.wdata = d;
        if (port) q1.push_back(r);
        else q0.push_back(r);
    endtask

    task automatic exp_push(input logic port, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.port = port; e.we = we; e.addr = a; e.wdata = d;
        sb.push_back(e);
    endtask

    task automatic clear_marks();
        rise_q.delete();
        done_q.delete();
        fall_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 500), 32'd1);
    endtask

    task automatic wait_sv(input string tag);
        int n = 0;
        while (!sram_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_sv_timeout"}, 32'(n < 50), 32'd1);
    endtask

    task automatic gap_checks(input string tag);
        for (int k = 0; k + 1 < rise_q.size() && k < done_q.size(); k++)
            check({tag, "_gap"}, 32'(rise_q[k+1] - done_q[k]), 32'd2);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, r0, r1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sram_valid", 32'(sram_valid), 32'd0);
        check("rst_sram_we", 32'(sram_we), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_sram_wdata", 32'(sram_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd1);
        check("rst_ready", 32'(m0_ready | m1_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // single port-0 write, driver ready in the 4th request cycle
        clear_marks();
        t0 = cyc;
        req(1'b0, 1'b1, 1'b0, 19'h00010, 16'hA5A5);
        exp_push(1'b0, 1'b1, 19'h00010, 16'hA5A5);
        repeat (6) @(negedge clk);
        check("t1_gap_busy", 32'(busy), 32'd1);
        check("t1_gap_valid", 32'(sram_valid), 32'd0);
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);
        wait_idle("t1");
        check("t1_nrise", 32'(rise_q.size()), 32'd1);
        if (rise_q.size() > 0) check("t1_rise_cyc", 32'(rise_q[0] - t0), 32'd2);
        if (done_q.size() > 0) check("t1_done_cyc", 32'(done_q[0] - t0), 32'd5);
        if (fall_q.size() > 0) check("t1_fall_cyc", 32'(fall_q[0] - t0), 32'd6);
        check("t1_m0_pulses", 32'(rdy0_n), 32'd1);
        check("t1_m1_pulses", 32'(rdy1_n), 32'd0);

        // simultaneous reads straight after reset: port 0 then port 1
        pulse_reset();
        clear_marks();
        req(1'b0, 1'b0, 1'b0, 19'h00001, 16'h0);
        req(1'b1, 1'b0, 1'b0, 19'h00002, 16'h0);
        exp_push(1'b0, 1'b0, 19'h00001, 16'h0);
        exp_push(1'b1, 1'b0, 19'h00002, 16'h0);
        wait_idle("t2");
        check("t2_nrise", 32'(rise_q.size()), 32'd2);
        gap_checks("t2");

        // continuous contention without lock: strict alternation
        clear_marks();
        r0 = rdy0_n;
        r1 = rdy1_n;
        for (int i = 0; i < 4; i++) begin
            req(1'b0, i[0], 1'b0, 19'(32'h20 + i), 16'(32'h1000 + i));
            req(1'b1, ~i[0], 1'b0, 19'(32'h40 + i), 16'(32'h2000 + i));
            exp_push(1'b0, i[0], 19'(32'h20 + i), 16'(32'h1000 + i));
            exp_push(1'b1, ~i[0], 19'(32'h40 + i), 16'(32'h2000 + i));
        end
        wait_idle("t3");
        check("t3_m0_pulses", 32'(rdy0_n - r0), 32'd4);
        check("t3_m1_pulses", 32'(rdy1_n - r1), 32'd4);
        gap_checks("t3");

        // lock keeps a 32-bit access atomic against a waiting port 1
        clear_marks();
        req(1'b0, 1'b1, 1'b1, 19'h00100, 16'h1234);
        req(1'b0, 1'b1, 1'b0, 19'h00101, 16'h5678);
        req(1'b1, 1'b0, 1'b0, 19'h00200, 16'h0);
        exp_push(1'b0, 1'b1, 19'h00100, 16'h1234);
        exp_push(1'b0, 1'b1, 19'h00101, 16'h5678);
        exp_push(1'b1, 1'b0, 19'h00200, 16'h0);
        wait_idle("t4");
        check("t4_nrise", 32'(rise_q.size()), 32'd3);
        gap_checks("t4");

        // burst cap: four locked port-0 grants, then the waiting port 1
        clear_marks();
        for (int i = 0; i < 6; i++)
            req(1'b0, 1'b0, (i != 5), 19'(32'h300 + i), 16'h0);
        req(1'b1, 1'b0, 1'b0, 19'h00400, 16'h0);
        for (int i = 0; i < 4; i++) exp_push(1'b0, 1'b0, 19'(32'h300 + i), 16'h0);
        exp_push(1'b1, 1'b0, 19'h00400, 16'h0);
        exp_push(1'b0, 1'b0, 19'h00304, 16'h0);
        exp_push(1'b0, 1'b0, 19'h00305, 16'h0);
        wait_idle("t5");
        check("t5_nrise", 32'(rise_q.size()), 32'd7);

        // requester drops valid and scrambles fields mid-grant
        req(1'b1, 1'b1, 1'b0, 19'h00055, 16'hBEEF);
        exp_push(1'b1, 1'b1, 19'h00055, 16'hBEEF);
        wait_sv("t6");
        drop1 = 1'b1;
        wait_idle("t6");
        drop1 = 1'b0;

        // async reset in the middle of a grant
        req(1'b1, 1'b0, 1'b0, 19'h00066, 16'h0);
        wait_sv("t7");
        @(negedge clk);
        check("t7_pre_valid", 32'(sram_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t7_rst_valid", 32'(sram_valid), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_owner", 32'(owner), 32'd1);
        q1.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_marks();
        req(1'b0, 1'b0, 1'b0, 19'h00070, 16'h0);
        req(1'b1, 1'b0, 1'b0, 19'h00071, 16'h0);
        exp_push(1'b0, 1'b0, 19'h00070, 16'h0);
        exp_push(1'b1, 1'b0, 19'h00071, 16'h0);
        wait_idle("t7b");
        gap_checks("t7b");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 16-bit SRAM driver (valid/ready/we/addr[18:0]/wdata/rdata) between two requesters.
- Port 0 is the CPU path (SRAM processor); port 1 is a secondary master (DMA or firmware loader).
- Round-robin arbitration, with optional lock so a 32-bit access (two 16-bit halves) or a short burst stays atomic.
- Captures the winning request into registers and holds the driver request stable until the driver's ready pulse.

Parameters:
ADDR_WIDTH, 19, SRAM word address width
DATA_WIDTH, 16, SRAM data width
MAX_BURST, 4, max consecutive locked grants to one port before a waiting port must be served (>=1)

Ports:
clk  in  1  system clock (50 MHz domain)
reset  in  1  asynchronous, active-high reset
m0_valid  in  1  port 0 request; held until m0_ready
m0_we  in  1  port 0 write enable
m0_lock  in  1  port 0 requests keeping the grant for its next access
m0_addr  in  ADDR_WIDTH  port 0 word address
m0_wdata  in  DATA_WIDTH  port 0 write data
m0_ready  out  1  one-cycle completion pulse to port 0
m0_rdata  out  DATA_WIDTH  read data; valid when m0_ready=1
m1_valid, m1_we, m1_lock, m1_addr, m1_wdata, m1_ready, m1_rdata  same as port 0, for port 1
sram_valid  out  1  request to SRAM driver
sram_we  out  1  write enable to driver
sram_addr  out  ADDR_WIDTH  address to driver
sram_wdata  out  DATA_WIDTH  write data to driver
sram_ready  in  1  driver completion pulse
sram_rdata  in  DATA_WIDTH  driver read data
busy  out  1  high in GRANT or GAP
owner  out  1  port currently or last granted

Behaviour:
- Reset (async, active-high):
  - State returns to IDLE.
  - sram_valid, sram_we, m0_ready, m1_ready, busy = 0.
  - sram_addr and sram_wdata = 0.
  - owner = 1, so port 0 wins the first tie.
  - burst_cnt = 0.
- States:
  - IDLE: no transaction.
  - GRANT: request issued; waiting for sram_ready.
  - GAP: one idle cycle after each completion, with sram_valid=0. This guarantees a valid deassertion between driver transactions.
- Arbitration, evaluated in IDLE and in GAP:
  - Only one port valid: that port wins.
  - Both ports valid: the port != owner wins (round-robin).
  - Lock rule, in GAP only: if the owner's lock=1 at the ready cycle, owner valid=1, and burst_cnt < MAX_BURST-1, the owner wins regardless of the other port.
- Grant action:
  - Register winner we/addr/wdata into sram_we/addr/wdata.
  - Set sram_valid=1 and owner=winner; go to GRANT.
  - burst_cnt increments on a locked re-grant; otherwise it resets to 0.
  - Latency: request seen in IDLE at cycle N gives sram_valid=1 at cycle N+1.
- GRANT:
  - sram_valid and the captured fields are held constant until sram_ready=1, whatever the requester inputs do.
  - On sram_ready:
    - mN_ready = 1 combinationally for N = owner, in the same cycle.
    - mN_rdata = sram_rdata; m0_rdata and m1_rdata both carry sram_rdata, qualified by ready.
    - The non-owner's ready stays 0.
    - sram_valid clears on the next edge and the state moves to GAP.
- GAP:
  - Requesters must drop or refresh valid by this cycle.
  - A winner present gives a grant (sram_valid=1 next cycle); otherwise go to IDLE.
  - A requester that keeps valid high after its ready is treated as a new request.
- Lock: sampled from the owner at its ready cycle. The lock of a port not currently owning the grant is ignored.
- Starvation bound: a waiting port is granted within MAX_BURST owner transactions.
- Owner deasserts valid in GRANT (protocol violation): the captured transaction still completes. The ready pulse is still emitted and may be ignored.
- Reset mid-GRANT: sram_valid drops immediately. The driver shares the same reset source, so no half transaction persists.
- Maximum throughput: one transaction per (driver latency + 1) cycles.

Test Plan:
- Single port 0 write: m0 addr=0x00010, wdata=0xA5A5, we=1, driver ready after 3 cycles -> sram_valid high cycles 1-4, one m0_ready pulse, m1_ready never set.
- Simultaneous request after reset: m0 and m1 valid at the same cycle, reads of 0x00001 and 0x00002 -> port 0 served first, then port 1 after one GAP cycle; owner 0 then 1.
- Continuous contention: both ports valid for 8 transactions, no lock -> strict alternation 0,1,0,1...; each port gets 4 ready pulses.
- Lock atomicity: m0_lock=1 for a 32-bit access (0x00100, 0x00101) while m1 valid -> both m0 halves are served back-to-back before m1; sram_valid=0 for exactly one cycle between them.
- Burst cap, MAX_BURST=4: m0_lock held with m1 waiting -> at most 4 consecutive m0 grants, then m1 is granted.
- Async reset pulse mid-GRANT -> sram_valid=0 and busy=0 without a clock edge; the next request after release is granted to port 0 on a tie.
